alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, the command FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the command-side valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the command-side ready, high while the FIFO is not full.
REQ-006 The block SHALL have ports in_a and in_b, input, 8 bits each: the command operands.
REQ-007 The block SHALL have port in_op, input, 3 bits: the ALU opcode, encoded 000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101 and, 110 or, 111 xor.
REQ-008 The block SHALL have ports alu_a and alu_b, output, 8 bits each, and alu_op, output, 3 bits: registered operands and opcode driven to the downstream 8-bit ALU.
REQ-009 The block SHALL have port alu_out, input, 16 bits: the ALU result.
REQ-010 The block SHALL have port alu_cb, input, 1 bit: the ALU carry/borrow.
REQ-011 The block SHALL have port res_valid, output, 1 bit: the result-side valid.
REQ-012 The block SHALL have port res_ready, input, 1 bit: the result-side ready.
REQ-013 The block SHALL have port res_data, output, 16 bits: the captured result.
REQ-014 The block SHALL have port res_cb, output, 1 bit: the captured carry/borrow.
REQ-015 The block SHALL have port occupancy, output, clog2(DEPTH)+1 bits: the current FIFO entry count.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-017 A command SHALL be accepted and written at the FIFO tail on any edge where in_valid and in_ready are both high; the block SHALL never drop or duplicate a command.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-019 A push and a pop on the same edge SHALL leave occupancy unchanged; when the FIFO is full, in_ready SHALL be low and a pop on that edge SHALL raise in_ready on the next cycle only.
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC and HOLD.
REQ-021 In IDLE with occupancy>0, the FSM SHALL pop the head into alu_a/alu_b/alu_op and move to EXEC; in IDLE with occupancy=0, the FSM SHALL stay in IDLE.
REQ-022 EXEC SHALL last exactly one cycle, at whose end the block captures alu_out into res_data and sets res_valid, then moves to HOLD.
REQ-023 At the same EXEC-end edge, res_cb SHALL be set to alu_cb when alu_op is 000 or 001, and to 0 otherwise.
REQ-024 In HOLD, res_valid, res_data and res_cb SHALL be held stable until res_valid and res_ready are both high.
REQ-025 On the HOLD handshake edge with occupancy>0, the block SHALL pop the next command, clear res_valid and go to EXEC; with occupancy=0, it SHALL clear res_valid and go to IDLE.
REQ-026 Latency SHALL be 2 edges: for a command accepted at edge T into an empty FIFO with the FSM in IDLE, res_valid SHALL be high from edge T+2.
REQ-027 Sustained throughput SHALL be one result per 2 cycles when res_ready is held high.
REQ-028 alu_a, alu_b and alu_op SHALL hold their last values outside EXEC.
REQ-029 res_data SHALL be passed through unmodified as 16 bits, with no sign or width adjustment.

Reset
REQ-030 While rst_n is low, the block SHALL force the FSM to IDLE; pointers, occupancy, res_valid, res_data, res_cb, alu_a, alu_b, alu_op and busy to 0; and in_ready to 1.
REQ-031 Reset asserted mid-operation (EXEC or HOLD, or with the FIFO non-empty) SHALL discard all queued and in-flight commands, and no result SHALL be presented after release.
REQ-032 The first command SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-033 With macro ALU_SEQ_ZERO_FLAG_EN defined, the block SHALL add output res_zero, 1 bit, captured together with res_data, high when alu_out==16'h0000, and reset to 0.
REQ-034 Without ALU_SEQ_ZERO_FLAG_EN, port res_zero and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL cover: add, A=8'hF0, B=8'h20, res_ready=1 -> res_data=16'h0010, res_cb=1, res_valid at the 2nd edge after acceptance.
REQ-036 The bench SHALL cover: sub, A=8'h05, B=8'h07 -> res_data=16'h00FE, res_cb=1; then mul, A=8'hFF, B=8'hFF -> res_data=16'hFE01, res_cb=0.
REQ-037 The bench SHALL cover: DEPTH=4, res_ready=0, back-to-back commands -> exactly 5 accepted, in_ready low, occupancy=4; raising res_ready -> 5 results returned in order.
REQ-038 The bench SHALL cover: res_ready toggled randomly for 3 HOLD cycles -> res_data and res_cb stable until the handshake, with no result lost.
REQ-039 The bench SHALL cover: rst_n pulsed low during EXEC with 2 entries queued -> res_valid=0, occupancy=0, in_ready=1, busy=0, and no later results.
REQ-040 The bench SHALL cover: with ALU_SEQ_ZERO_FLAG_EN defined, xor, A=8'h5A, B=8'h5A -> res_data=16'h0000, res_zero=1.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Buffers ALU commands in a small FIFO, issues them one at a time to an
// external 8-bit ALU through registered operand/opcode outputs, captures the
// ALU result one cycle later and presents it on a valid/ready result port.
//
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
//   When defined, adds output res_zero (result == 0, captured with res_data).
//
// Parameters
//   DEPTH      command FIFO depth in entries (power of two, 2..16)
//
// Ports
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   command valid
//   in_ready   command ready (FIFO not full)
//   in_a/in_b  command operands, 8 bits
//   in_op      opcode: 000 add, 001 sub, 010 mul, 011 shl,
//                      100 shr, 101 and, 110 or, 111 xor
//   alu_a/b    registered operands to the ALU
//   alu_op     registered opcode to the ALU
//   alu_out    ALU result, 16 bits
//   alu_cb     ALU carry/borrow
//   res_valid  result valid
//   res_ready  result ready
//   res_data   captured result, 16 bits, unmodified
//   res_cb     captured carry/borrow (add/sub only, else 0)
//   res_zero   captured zero flag (ALU_SEQ_ZERO_FLAG_EN only)
//   occupancy  FIFO entry count, 0..DEPTH
//   busy       FSM not in IDLE
//
// FSM states
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no command in flight; pops the FIFO head when one is queued
//   EXEC  | operands on the ALU for one cycle; result captured at its end
//   HOLD  | result presented, held until the res_valid/res_ready handshake
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic [2:0]               in_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [2:0]               alu_op,
  input  logic [15:0]              alu_out,
  input  logic                     alu_cb,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_data,
  output logic                     res_cb,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                     res_zero,
`endif
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic          capture;
  logic          release_res;
  logic          not_empty;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  // in_ready is a function of the registered count only, so a pop on a
  // full edge frees a slot for the following cycle, never the same one.
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_op};
    end
  end

  // DEPTH is a power of two, so the natural pointer rollover is modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= PW'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_ptr <= PW'(rd_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pops only ever come from the registered count, so a command pushed
  // into an empty FIFO is seen by IDLE one edge later (2-edge latency).
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (not_empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          if (not_empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------
  // ALU operand registers: loaded on pop, otherwise hold their last value
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (pop) begin
      alu_a  <= head.a;
      alu_b  <= head.b;
      alu_op <= head.op;
    end
  end

  // ---------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------
  // Carry/borrow is only meaningful for add and sub; other ops report 0
  // regardless of what the ALU drives on alu_cb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cb    <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_cb    <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) ? alu_cb : 1'b0;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_zero <= 1'b0;
    end else if (capture) begin
      res_zero <= (alu_out == 16'h0000);
    end
  end
`endif

endmodule
